fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer_if.sv | 54 +++++
 rtl/fetch_sequencer.sv | 129 ++++++++++++
 tb/tb_fetch_sequencer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Decoder-facing bundle for fetch_sequencer.
// The master (control decoder / program controller) drives start, branch and
// compare information and the returned instruction word; the slave
// (fetch_sequencer) drives the PC, mode, latched instruction, flags and status.
//   start                 program start request (level, rising edge acted on)
//   branch_en/_target     take branch_target as the next PC
//   next_state            decoder mode for the next instruction
//   prev_instruction_out  current instruction word returned for latching
//   cmp_bits_out          compare flags passed through by the decoder
//   cmp_load_en/cmp_new   load fresh compare flags {zero, equal, gt}
//   ack                   decoder done-instruction flag (ends the program)
//   prog_ctr              instruction ROM address
//   curr_state            decoder mode register
//   prev_instruction      instruction word latched in the previous cycle
//   cmp_bits              compare flag register
//   running / done        RUN / HALT state decodes
//   cycle_count           RUN cycles of the current or last program
interface fetch_sequencer_if #(
  parameter int unsigned CYC_W = 16
);

  logic             start;
  logic             branch_en;
  logic [8:0]       branch_target;
  logic [1:0]       next_state;
  logic [8:0]       prev_instruction_out;
  logic [2:0]       cmp_bits_out;
  logic             cmp_load_en;
  logic [2:0]       cmp_new;
  logic             ack;

  logic [8:0]       prog_ctr;
  logic [1:0]       curr_state;
  logic [8:0]       prev_instruction;
  logic [2:0]       cmp_bits;
  logic             running;
  logic             done;
  logic [CYC_W-1:0] cycle_count;

  modport master (
    output start, branch_en, branch_target, next_state, prev_instruction_out,
           cmp_bits_out, cmp_load_en, cmp_new, ack,
    input  prog_ctr, curr_state, prev_instruction, cmp_bits, running, done,
           cycle_count
  );

  modport slave (
    input  start, branch_en, branch_target, next_state, prev_instruction_out,
           cmp_bits_out, cmp_load_en, cmp_new, ack,
    output prog_ctr, curr_state, prev_instruction, cmp_bits, running, done,
           cycle_count
  );

endinterface

// File: rtl/fetch_sequencer.sv
// Program fetch sequencer: IDLE -> RUN -> HALT controller that steps the
// instruction ROM address one instruction per RUN cycle, follows branches,
// latches decoder mode / instruction word / compare flags and counts RUN
// cycles. All outputs are registered.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-low reset
//   bus    fetch_sequencer_if.slave (decoder handshake and status, see _if)
module fetch_sequencer #(
  parameter logic [8:0]  START_PC = 9'd0,
  parameter int unsigned CYC_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  fetch_sequencer_if.slave bus
);

  localparam int unsigned PC_W   = 9;
  localparam int unsigned MODE_W = 2;
  localparam int unsigned CMP_W  = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              start_q;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [PC_W-1:0]   prev_q, prev_d;
  logic [CMP_W-1:0]  cmp_q, cmp_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic              running_q, running_d;
  logic              done_q, done_d;

  logic              start_rise;
  logic [CYC_W-1:0]  cyc_sat_inc;

  // start_q is cleared by reset, so a start held through reset release
  // is seen as a rising edge on the first cycle out of reset.
  assign start_rise = bus.start & ~start_q;

  // Saturating increment of the RUN cycle counter.
  assign cyc_sat_inc = (cyc_q == {CYC_W{1'b1}}) ? cyc_q : cyc_q + CYC_W'(1);

  // Next-state and next-register logic.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    mode_d    = mode_q;
    prev_d    = prev_q;
    cmp_d     = cmp_q;
    cyc_d     = cyc_q;
    running_d = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE, S_HALT: begin
        if (start_rise) begin
          state_d = S_RUN;
          pc_d    = START_PC;
          mode_d  = '0;
          prev_d  = '0;
          cmp_d   = '0;
          cyc_d   = '0;
        end
      end

      S_RUN: begin
        // The ack cycle still counts as an executed cycle.
        cyc_d = cyc_sat_inc;
        if (bus.ack) begin
          // Program ends: everything but the counter freezes, branch ignored.
          state_d = S_HALT;
        end else begin
          pc_d   = bus.branch_en ? bus.branch_target : pc_q + PC_W'(1);
          // Mode 11 (NOP) is stored as regular mode.
          mode_d = (bus.next_state == 2'b11) ? 2'b00 : bus.next_state;
          prev_d = bus.prev_instruction_out;
          cmp_d  = bus.cmp_load_en ? bus.cmp_new : bus.cmp_bits_out;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status flags are decodes of the next state, registered with it.
    running_d = (state_d == S_RUN);
    done_d    = (state_d == S_HALT);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      start_q   <= 1'b0;
      pc_q      <= START_PC;
      mode_q    <= '0;
      prev_q    <= '0;
      cmp_q     <= '0;
      cyc_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= bus.start;
      pc_q      <= pc_d;
      mode_q    <= mode_d;
      prev_q    <= prev_d;
      cmp_q     <= cmp_d;
      cyc_q     <= cyc_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign bus.prog_ctr         = pc_q;
  assign bus.curr_state       = mode_q;
  assign bus.prev_instruction = prev_q;
  assign bus.cmp_bits         = cmp_q;
  assign bus.running          = running_q;
  assign bus.done             = done_q;
  assign bus.cycle_count      = cyc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer. A second instance with a
// 3-bit cycle counter exercises counter saturation alongside the main run.
module tb_fetch_sequencer;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  fetch_sequencer_if #(.CYC_W(16)) bus ();
  fetch_sequencer_if #(.CYC_W(3))  bus2 ();

  fetch_sequencer #(.START_PC(9'd0), .CYC_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  fetch_sequencer #(.START_PC(9'd0), .CYC_W(3)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_run(input string tag, input logic [8:0] pc, input logic [15:0] cc);
    check({tag, "_pc"}, 32'(bus.prog_ctr), 32'(pc));
    check({tag, "_cc"}, 32'(bus.cycle_count), 32'(cc));
    check({tag, "_running"}, 32'(bus.running), 32'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.branch_en = 1'b0;
    bus.branch_target = '0;
    bus.next_state = '0;
    bus.prev_instruction_out = '0;
    bus.cmp_bits_out = '0;
    bus.cmp_load_en = 1'b0;
    bus.cmp_new = '0;
    bus.ack = 1'b0;
    bus2.start = 1'b0;
    bus2.branch_en = 1'b0;
    bus2.branch_target = '0;
    bus2.next_state = '0;
    bus2.prev_instruction_out = '0;
    bus2.cmp_bits_out = '0;
    bus2.cmp_load_en = 1'b0;
    bus2.cmp_new = '0;
    bus2.ack = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_pc", 32'(bus.prog_ctr), 32'd0);
    check("rst_mode", 32'(bus.curr_state), 32'd0);
    check("rst_prev", 32'(bus.prev_instruction), 32'd0);
    check("rst_cmp", 32'(bus.cmp_bits), 32'd0);
    check("rst_running", 32'(bus.running), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_cc", 32'(bus.cycle_count), 32'd0);

    // Idle holds without start
    reset = 1'b1;
    tick();
    check("idle_running", 32'(bus.running), 32'd0);

    // Start pulse (both instances)
    bus.start = 1'b1;
    bus2.start = 1'b1;
    tick();
    check_run("start", 9'd0, 16'd0);
    check("start_done", 32'(bus.done), 32'd0);
    bus.start = 1'b0;
    bus2.start = 1'b0;

    // Three sequential cycles
    tick();
    check_run("seq1", 9'd1, 16'd1);
    tick();
    check_run("seq2", 9'd2, 16'd2);
    tick();
    check_run("seq3", 9'd3, 16'd3);

    // Start rising in RUN is ignored
    bus.start = 1'b1;
    tick();
    check_run("start_in_run", 9'd4, 16'd4);
    bus.start = 1'b0;
    tick();
    check_run("pc5", 9'd5, 16'd5);

    // Branch from PC=5 to 0x120
    bus.branch_en = 1'b1;
    bus.branch_target = 9'h120;
    tick();
    check_run("branch", 9'h120, 16'd6);

    // Branch to 511 then wrap to 0
    bus.branch_target = 9'h1FF;
    tick();
    check_run("to511", 9'h1FF, 16'd7);
    check("sat_cc7", 32'(bus2.cycle_count), 32'd7);
    bus.branch_en = 1'b0;
    tick();
    check_run("wrap", 9'd0, 16'd8);
    check("sat_hold", 32'(bus2.cycle_count), 32'd7);

    // Mode register and instruction latch
    bus.next_state = 2'b01;
    bus.prev_instruction_out = 9'h10C;
    tick();
    check("mode01", 32'(bus.curr_state), 32'd1);
    check("prev_latch", 32'(bus.prev_instruction), 32'h10C);
    check_run("mode01", 9'd1, 16'd9);
    bus.next_state = 2'b11;
    tick();
    check("mode11_as_00", 32'(bus.curr_state), 32'd0);
    check("prev_keep", 32'(bus.prev_instruction), 32'h10C);
    bus.next_state = 2'b10;
    tick();
    check("mode10", 32'(bus.curr_state), 32'd2);
    check_run("mode10", 9'd3, 16'd11);
    bus.next_state = 2'b00;

    // Compare flags: load new, then pass-through
    bus.cmp_load_en = 1'b1;
    bus.cmp_new = 3'b011;
    bus.cmp_bits_out = 3'b100;
    tick();
    check("cmp_load", 32'(bus.cmp_bits), 32'b011);
    bus.cmp_load_en = 1'b0;
    tick();
    check("cmp_pass", 32'(bus.cmp_bits), 32'b100);
    check_run("cmp", 9'd5, 16'd13);

    tick();
    tick();
    check_run("pc7", 9'd7, 16'd15);

    // Ack with branch, new mode/flags/instruction and a start edge: halt, freeze
    bus.ack = 1'b1;
    bus.branch_en = 1'b1;
    bus.branch_target = 9'h055;
    bus.next_state = 2'b01;
    bus.prev_instruction_out = 9'h0AA;
    bus.cmp_load_en = 1'b1;
    bus.cmp_new = 3'b111;
    bus.start = 1'b1;
    tick();
    check("halt_done", 32'(bus.done), 32'd1);
    check("halt_running", 32'(bus.running), 32'd0);
    check("halt_pc", 32'(bus.prog_ctr), 32'd7);
    check("halt_mode", 32'(bus.curr_state), 32'd0);
    check("halt_prev", 32'(bus.prev_instruction), 32'h10C);
    check("halt_cmp", 32'(bus.cmp_bits), 32'b100);
    check("halt_cc", 32'(bus.cycle_count), 32'd16);
    bus.ack = 1'b0;
    bus.branch_en = 1'b0;
    bus.next_state = 2'b00;
    bus.cmp_load_en = 1'b0;

    // Start held high: no restart
    tick();
    tick();
    check("hold_done", 32'(bus.done), 32'd1);
    check("hold_pc", 32'(bus.prog_ctr), 32'd7);
    check("hold_cc", 32'(bus.cycle_count), 32'd16);

    // Start low then high: restart
    bus.start = 1'b0;
    tick();
    check("halt_idle_done", 32'(bus.done), 32'd1);
    bus.start = 1'b1;
    tick();
    check_run("restart", 9'd0, 16'd0);
    check("restart_done", 32'(bus.done), 32'd0);
    check("restart_prev", 32'(bus.prev_instruction), 32'd0);
    check("restart_cmp", 32'(bus.cmp_bits), 32'd0);
    bus.start = 1'b0;

    // Run to PC=40, then reset mid-run with start held through release
    for (int i = 0; i < 40; i++) tick();
    check_run("pc40", 9'd40, 16'd40);
    reset = 1'b0;
    bus.start = 1'b1;
    tick();
    check("midrst_running", 32'(bus.running), 32'd0);
    check("midrst_pc", 32'(bus.prog_ctr), 32'd0);
    check("midrst_cc", 32'(bus.cycle_count), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    reset = 1'b1;
    tick();
    check_run("rel_start", 9'd0, 16'd0);
    tick();
    check_run("no_retrigger", 9'd1, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
